// File: rtl/tmem_arbiter.sv
// tmem_arbiter: shares one single-port ternary memory between the fetch unit
// (read-only) and the load/store unit (read/write). Each transaction takes
// three cycles: grant in IDLE, strobe in ISSUE, and acknowledge in RESP.
// When both ports request, they alternate by round-robin. An address that
// contains a 2'b11 trit is acknowledged with an error and never reaches the
// memory.
module tmem_arbiter #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  // fetch port
  input  logic                       if_req,
  input  logic [2*MEM_ADDR_SIZE-1:0] if_addr,
  output logic                       if_ack,
  output logic [2*WORD_SIZE-1:0]     if_rdata,
  output logic                       if_err,
  // data port
  input  logic                       d_req,
  input  logic                       d_we,
  input  logic [2*MEM_ADDR_SIZE-1:0] d_addr,
  input  logic [2*WORD_SIZE-1:0]     d_wdata,
  output logic                       d_ack,
  output logic [2*WORD_SIZE-1:0]     d_rdata,
  output logic                       d_err,
  // memory side
  output logic                       mem_read_enable,
  output logic                       mem_write_enable,
  output logic [2*MEM_ADDR_SIZE-1:0] mem_address,
  output logic [2*WORD_SIZE-1:0]     mem_data_in,
  input  logic [2*WORD_SIZE-1:0]     mem_data_out,
  output logic                       busy
);
  localparam int DW = 2*WORD_SIZE;
  localparam int AW = 2*MEM_ADDR_SIZE;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  typedef enum logic {PORT_IF = 1'b0, PORT_D = 1'b1} port_e;

  // Fields of the granted transaction, frozen from grant to response.
  typedef struct packed {
    port_e         port;
    logic          we;
    logic          err;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  state_e state_q, state_d;
  port_e  last_q, last_d;
  port_e  gnt;
  txn_t   txn_q, txn_d;
  logic   re_q, re_d;
  logic   we_q, we_d;
  logic   resp_ok;

  // An address is unusable if any of its trits uses the reserved code 2'b11.
  function automatic logic has_bad_trit(input logic [AW-1:0] a);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < MEM_ADDR_SIZE; i++)
      bad = bad | (a[2*i +: 2] == 2'b11);
    return bad;
  endfunction

  // Next-state logic: grant and latch in IDLE, record the winner in ISSUE.
  // The strobes are computed one cycle ahead so that they are registered.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    txn_d   = txn_q;
    gnt     = PORT_IF;
    re_d    = 1'b0;
    we_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          if (if_req && d_req) gnt = (last_q == PORT_D) ? PORT_IF : PORT_D;
          else                 gnt = d_req ? PORT_D : PORT_IF;
          txn_d.port  = gnt;
          txn_d.addr  = (gnt == PORT_D) ? d_addr : if_addr;
          txn_d.we    = (gnt == PORT_D) & d_we;
          txn_d.wdata = (gnt == PORT_D) ? d_wdata : '0;
          txn_d.err   = has_bad_trit(txn_d.addr);
          re_d        = ~txn_d.err & ~txn_d.we;
          we_d        = ~txn_d.err &  txn_d.we;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        last_d  = txn_q.port;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer, latched transaction, and memory strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= PORT_D;
      txn_q   <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      txn_q   <= txn_d;
      re_q    <= re_d;
      we_q    <= we_d;
    end
  end

  assign mem_read_enable  = re_q;
  assign mem_write_enable = we_q;
  assign mem_address      = txn_q.addr;
  assign mem_data_in      = txn_q.wdata;
  assign busy             = (state_q == ISSUE) || (state_q == RESP);

  // A reset that lands in the RESP cycle still suppresses the acknowledge,
  // because reset takes precedence over completing the transaction.
  assign resp_ok  = (state_q == RESP) && !reset;

  assign if_ack   = resp_ok && (txn_q.port == PORT_IF);
  assign d_ack    = resp_ok && (txn_q.port == PORT_D);
  assign if_err   = if_ack && txn_q.err;
  assign d_err    = d_ack  && txn_q.err;
  assign if_rdata = (if_ack && !txn_q.err && !txn_q.we) ? mem_data_out : '0;
  assign d_rdata  = (d_ack  && !txn_q.err && !txn_q.we) ? mem_data_out : '0;

endmodule

// File: tb/tb_tmem_arbiter.sv
// Bench for tmem_arbiter. A transaction-level reference model predicts every
// output in every cycle. Directed scenarios are followed by random traffic.
module tb_tmem_arbiter;
  localparam int WS = 9;
  localparam int AS = 3;
  localparam int DW = 2*WS;
  localparam int AW = 2*AS;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack, if_err;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack, d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_read_enable, mem_write_enable, busy;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  always #5 clock = ~clock;

  tmem_arbiter #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Memory seen by the DUT, and the model's independent copy.
  logic [DW-1:0] tb_mem  [64];
  logic [DW-1:0] ref_mem [64];

  // Single-port memory with registered read data.
  always @(posedge clock) begin
    if (mem_write_enable) tb_mem[mem_address] = mem_data_in;
    if (mem_read_enable)  mem_data_out <= tb_mem[mem_address];
  end

  function automatic bit bad_addr(input logic [AW-1:0] a);
    for (int i = 0; i < AS; i++) if (a[2*i +: 2] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < WS; i++) w[2*i +: 2] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    for (int i = 0; i < AS; i++) a[2*i +: 2] = 2'($urandom_range(0, 2));
    if ($urandom_range(0, 7) == 0) a[2*$urandom_range(0, AS-1) +: 2] = 2'b11;
    return a;
  endfunction

  // Reference model state: at most one transaction in flight. Its age counts
  // cycles since the grant (1 = strobe cycle, 2 = acknowledge cycle).
  bit            act = 0, last_d = 1, post_rst = 0;
  int            age = 0;
  bit            t_port, t_we, t_err;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wd;
  bit            ifack_seen = 0, dack_seen = 0;
  int            n_ifack = 0, n_dack = 0;

  // Predict and compare all outputs in the middle of every cycle.
  always @(negedge clock) begin
    bit            e_re, e_we, e_busy, e_ifa, e_da, e_ife, e_de;
    logic [DW-1:0] e_ifr, e_dr;
    ifack_seen = if_ack;
    dack_seen  = d_ack;
    n_ifack += int'(if_ack);
    n_dack  += int'(d_ack);
    if (reset) begin
      chk("rst_if_ack", if_ack, 0);
      chk("rst_d_ack", d_ack, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_errs", {if_err, d_err}, 0);
      act = 0; last_d = 1; post_rst = 1;
    end else begin
      if (post_rst) begin
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_din", mem_data_in, 0);
        post_rst = 0;
      end
      e_re = 0; e_we = 0; e_busy = 0; e_ifa = 0; e_da = 0; e_ife = 0; e_de = 0;
      e_ifr = '0; e_dr = '0;
      if (act) begin
        age++;
        e_busy = 1;
        if (age == 1) begin
          e_re = !t_err && !t_we;
          e_we = !t_err && t_we;
          chk("mem_addr", mem_address, t_addr);
          if (e_we) begin
            chk("mem_din", mem_data_in, t_wd);
            ref_mem[t_addr] = t_wd;
          end
        end else begin
          if (t_port) begin
            e_da = 1; e_de = t_err;
            e_dr = (t_err || t_we) ? '0 : ref_mem[t_addr];
          end else begin
            e_ifa = 1; e_ife = t_err;
            e_ifr = t_err ? '0 : ref_mem[t_addr];
          end
          act = 0;
        end
      end else if (if_req || d_req) begin
        t_port = (if_req && d_req) ? !last_d : d_req;
        last_d = t_port;
        t_addr = t_port ? d_addr : if_addr;
        t_we   = t_port && d_we;
        t_wd   = d_wdata;
        t_err  = bad_addr(t_addr);
        act = 1; age = 0;
      end
      chk("rd_en", mem_read_enable, e_re);
      chk("wr_en", mem_write_enable, e_we);
      chk("busy", busy, e_busy);
      chk("if_ack", if_ack, e_ifa);
      chk("d_ack", d_ack, e_da);
      chk("if_err", if_err, e_ife);
      chk("d_err", d_err, e_de);
      chk("if_rdata", if_rdata, e_ifr);
      chk("d_rdata", d_rdata, e_dr);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Advance until the chosen port's ack has been seen (p=1: data port).
  task automatic wait_ack(input bit p);
    int n = 0;
    do begin step(); n++; end while (!(p ? dack_seen : ifack_seen) && n < 12);
    if (!(p ? dack_seen : ifack_seen)) chk(p ? "d_ack_timeout" : "if_ack_timeout", 0, 1);
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    if_req = 1; if_addr = a;
    wait_ack(0);
    if_req = 0;
  endtask

  task automatic data(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
    wait_ack(1);
    d_req = 0;
  endtask

  initial begin
    int s_if, s_d;
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = rand_word();
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[6'b00_01_10]  = 18'h05555;
    ref_mem[6'b00_01_10] = 18'h05555;

    reset = 1;
    repeat (2) step();
    reset = 0;

    // Fetch read, data write then read-back, invalid-trit address.
    fetch(6'b00_01_10);
    data(1, 6'b01_00_00, 18'h2AAAA);
    data(0, 6'b01_00_00, '0);
    data(0, 6'b11_00_01, 18'h15555);

    // Contention: both ports requesting continuously alternate.
    s_if = n_ifack; s_d = n_dack;
    if_req = 1; if_addr = 6'b00_00_01;
    d_req = 1; d_we = 0; d_addr = 6'b10_01_00;
    repeat (12) step();
    if_req = 0; d_req = 0;
    chk("cont_if_acks", n_ifack - s_if, 2);
    chk("cont_d_acks", n_dack - s_d, 2);

    // Reset during ISSUE aborts; a fresh tie afterwards goes to fetch.
    s_if = n_ifack;
    if_req = 1; if_addr = 6'b01_01_01;
    step();
    reset = 1;
    step();
    reset = 0;
    d_req = 1; d_we = 0; d_addr = 6'b00_10_10;
    wait_ack(0);
    if_req = 0;
    chk("rst_abort_if_acks", n_ifack - s_if, 1);
    wait_ack(1);
    d_req = 0;

    // Held request: one extra cycle of if_req starts a second fetch.
    s_if = n_ifack;
    if_req = 1; if_addr = 6'b10_00_10;
    wait_ack(0);
    step();
    if_req = 0;
    wait_ack(0);
    chk("held_if_acks", n_ifack - s_if, 2);

    // Random traffic with occasional resets and held requests.
    repeat (600) begin
      step();
      reset = ($urandom_range(0, 63) == 0);
      if (if_req) begin
        if (ifack_seen && $urandom_range(0, 4) != 0) if_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = rand_addr();
      end
      if (d_req) begin
        if (dack_seen && $urandom_range(0, 4) != 0) d_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = rand_addr(); d_wdata = DW'($urandom);
      end
    end
    reset = 0; if_req = 0; d_req = 0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
